// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver with a fixed-length command packet parser (A5, CMD, ADDR, DATA [, CHK]).
// Define UART_CMD_CHECKSUM_EN to require a trailing CHK = CMD ^ ADDR ^ DATA byte.
module uart_cmd_rx #(
  parameter int CLK_FREQ     = 25_000_000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] conf_addr,
  output logic [7:0] conf_data,
  output logic       sccb_start,
  output logic       take_pic,
  output logic       hdr_en,
  output logic       cmd_err,
  output logic       rx_busy
);
  localparam int CW       = $clog2(CLKS_PER_BIT);
  localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW       = $clog2(TO_LIMIT + 1);
  localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bstate_t;
`ifdef UART_CMD_CHECKSUM_EN
  typedef enum logic [2:0] {P_HUNT, P_CMD, P_ADDR, P_DATA, P_CHK} pstate_t;
`else
  typedef enum logic [2:0] {P_HUNT, P_CMD, P_ADDR, P_DATA} pstate_t;
`endif

  logic          rx_meta_q, rx_s_q;
  bstate_t       bstate_q, bstate_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          byte_valid, frame_err;

  pstate_t       pstate_q, pstate_d;
  logic [7:0]    cmd_q, cmd_d, addr_q, addr_d, data_q, data_d;
  logic [TW-1:0] to_q, to_d;
  logic [7:0]    conf_addr_q, conf_addr_d, conf_data_q, conf_data_d;
  logic          sccb_q, sccb_d, pic_q, pic_d, hdr_q, hdr_d, err_q, err_d;
  logic          exec;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      bstate_q    <= B_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shreg_q     <= '0;
      pstate_q    <= P_HUNT;
      cmd_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      to_q        <= '0;
      conf_addr_q <= '0;
      conf_data_q <= '0;
      sccb_q      <= 1'b0;
      pic_q       <= 1'b0;
      hdr_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      rx_meta_q   <= rx;
      rx_s_q      <= rx_meta_q;
      bstate_q    <= bstate_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      pstate_q    <= pstate_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      to_q        <= to_d;
      conf_addr_q <= conf_addr_d;
      conf_data_q <= conf_data_d;
      sccb_q      <= sccb_d;
      pic_q       <= pic_d;
      hdr_q       <= hdr_d;
      err_q       <= err_d;
    end
  end

  // Byte deserialiser: every sample lands at a bit centre, counted from the start-bit edge.
  always_comb begin
    bstate_d   = bstate_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    case (bstate_q)
      B_IDLE: begin
        if (!rx_s_q) begin
          cnt_d    = HALF_BIT;
          bstate_d = B_START;
        end
      end
      B_START: begin
        if (cnt_q == '0) begin
          if (rx_s_q) begin
            bstate_d = B_IDLE;
          end else begin
            bstate_d = B_DATA;
            cnt_d    = FULL_BIT;
            bit_d    = 3'd0;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      B_DATA: begin
        if (cnt_q == '0) begin
          shreg_d = {rx_s_q, shreg_q[7:1]};
          cnt_d   = FULL_BIT;
          if (bit_q == 3'd7) bstate_d = B_STOP;
          else               bit_d    = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        if (cnt_q == '0) begin
          bstate_d = B_IDLE;
          if (rx_s_q) byte_valid = 1'b1;
          else        frame_err  = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
    endcase
  end

  // Packet parser; effects of a complete packet are registered, so they appear one cycle after the last byte.
  always_comb begin
    pstate_d    = pstate_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    data_d      = data_q;
    to_d        = to_q;
    conf_addr_d = conf_addr_q;
    conf_data_d = conf_data_q;
    sccb_d      = 1'b0;
    pic_d       = 1'b0;
    hdr_d       = hdr_q;
    err_d       = 1'b0;
    exec        = 1'b0;

    if (byte_valid || pstate_q == P_HUNT) begin
      to_d = '0;
    end else if (bstate_q == B_IDLE) begin
      to_d = to_q + TW'(1);
    end

    if (frame_err) begin
      err_d    = 1'b1;
      pstate_d = P_HUNT;
    end else if (byte_valid) begin
      case (pstate_q)
        P_HUNT: if (shreg_q == 8'hA5) pstate_d = P_CMD;
        P_CMD: begin
          cmd_d    = shreg_q;
          pstate_d = P_ADDR;
        end
        P_ADDR: begin
          addr_d   = shreg_q;
          pstate_d = P_DATA;
        end
`ifdef UART_CMD_CHECKSUM_EN
        P_DATA: begin
          data_d   = shreg_q;
          pstate_d = P_CHK;
        end
        default: begin
          pstate_d = P_HUNT;
          if (shreg_q == (cmd_q ^ addr_q ^ data_q)) exec  = 1'b1;
          else                                     err_d = 1'b1;
        end
`else
        default: begin
          data_d   = shreg_q;
          pstate_d = P_HUNT;
          exec     = 1'b1;
        end
`endif
      endcase
    end else if (pstate_q != P_HUNT && bstate_q == B_IDLE && to_q == TW'(TO_LIMIT - 1)) begin
      err_d    = 1'b1;
      pstate_d = P_HUNT;
      to_d     = '0;
    end

    if (exec) begin
      case (cmd_q)
        8'h01: begin
          conf_addr_d = addr_q;
          conf_data_d = data_d;
          sccb_d      = 1'b1;
        end
        8'h02:   pic_d = 1'b1;
        8'h03:   hdr_d = data_d[0];
        default: err_d = 1'b1;
      endcase
    end
  end

  assign conf_addr  = conf_addr_q;
  assign conf_data  = conf_data_q;
  assign sccb_start = sccb_q;
  assign take_pic   = pic_q;
  assign hdr_en     = hdr_q;
  assign cmd_err    = err_q;
  assign rx_busy    = (pstate_q != P_HUNT);
endmodule

// File: tb/tb_uart_cmd_rx.sv
// Scoreboard bench for uart_cmd_rx: a packet-level model queues expected output events, a monitor pops them.
module tb_uart_cmd_rx;
  localparam int CPB      = 16;
  localparam int TOB      = 40;
  localparam int TO_LIMIT = CPB * TOB;
  localparam logic [3:0] K_SCCB = 4'b1000, K_PIC = 4'b0100, K_ERR = 4'b0010, K_HDR = 4'b0001;

  logic clk = 1'b0, rst = 1'b1, rx = 1'b1;
  logic [7:0] conf_addr, conf_data;
  logic sccb_start, take_pic, hdr_en, cmd_err, rx_busy;

  uart_cmd_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .conf_addr(conf_addr), .conf_data(conf_data),
    .sccb_start(sccb_start), .take_pic(take_pic), .hdr_en(hdr_en),
    .cmd_err(cmd_err), .rx_busy(rx_busy)
  );

  always #20 clk = ~clk;

  typedef struct {
    logic [3:0] kind;
    logic [7:0] addr;
    logic [7:0] data;
    logic       hdr;
  } ev_t;

  ev_t exp_q[$];
  int n_total = 0, n_pass = 0, cyc = 0;
  logic [7:0] m_addr = 8'h00, m_data = 8'h00;
  logic m_hdr = 1'b0, hdr_prev = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic push_ev(input logic [3:0] k);
    exp_q.push_back('{kind: k, addr: m_addr, data: m_data, hdr: m_hdr});
  endtask

  always @(negedge clk) begin
    logic [3:0] seen;
    ev_t e;
    if (rst) begin
      hdr_prev = 1'b0;
    end else begin
      seen = {sccb_start, take_pic, cmd_err, hdr_en !== hdr_prev};
      hdr_prev = hdr_en;
      if (seen != 4'b0000) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", {28'd0, seen}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          $display("[%0d] event kind=%b addr=%02h data=%02h hdr=%0b", cyc, seen, conf_addr, conf_data, hdr_en);
          check("event_kind", {28'd0, seen}, {28'd0, e.kind});
          check("conf_addr", {24'd0, conf_addr}, {24'd0, e.addr});
          check("conf_data", {24'd0, conf_data}, {24'd0, e.data});
          check("hdr_en", {31'd0, hdr_en}, {31'd0, e.hdr});
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit good_stop, input int gap);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    if (good_stop) begin
      rx = 1'b1;
      repeat (CPB) @(negedge clk);
    end else begin
      rx = 1'b0;
      repeat (CPB * 3 / 4) @(negedge clk);
      rx = 1'b1;
      repeat (CPB - CPB * 3 / 4) @(negedge clk);
    end
    rx = 1'b1;
    repeat (gap * CPB) @(negedge clk);
  endtask

  // Packet-level reference: the outcome is decided from the whole packet before it is sent.
  task automatic send_packet(input logic [7:0] cmd, input logic [7:0] addr, input logic [7:0] data,
                             input int ferr_at, input bit bad_chk, input int gap);
    logic [7:0] pkt [5];
    int n;
    pkt[0] = 8'hA5; pkt[1] = cmd; pkt[2] = addr; pkt[3] = data;
    pkt[4] = cmd ^ addr ^ data ^ {7'd0, bad_chk};
`ifdef UART_CMD_CHECKSUM_EN
    n = 5;
`else
    n = 4;
`endif
    if (ferr_at >= 0 && ferr_at < n) begin
      push_ev(K_ERR);
`ifdef UART_CMD_CHECKSUM_EN
    end else if (bad_chk) begin
      push_ev(K_ERR);
`endif
    end else begin
      case (cmd)
        8'h01: begin m_addr = addr; m_data = data; push_ev(K_SCCB); end
        8'h02: push_ev(K_PIC);
        8'h03: if (data[0] != m_hdr) begin m_hdr = data[0]; push_ev(K_HDR); end
        default: push_ev(K_ERR);
      endcase
    end
    for (int i = 0; i < n; i++) begin
      if (i == ferr_at) begin
        send_byte(pkt[i], 1'b0, 2);
        break;
      end
      send_byte(pkt[i], 1'b1, gap);
    end
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 4 * CPB) begin
      @(negedge clk);
      t++;
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    int t0, t;
    logic [7:0] c, j;
    repeat (4) @(negedge clk);
    check("reset_outputs", {conf_addr, conf_data, 3'd0, sccb_start, take_pic, hdr_en, cmd_err, rx_busy}, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // write command, zero inter-byte gap
    send_byte(8'hA5, 1'b1, 0);
    check("busy_after_sync", {31'd0, rx_busy}, 1);
    m_addr = 8'h12; m_data = 8'h80; push_ev(K_SCCB);
    send_byte(8'h01, 1'b1, 0);
    send_byte(8'h12, 1'b1, 0);
    send_byte(8'h80, 1'b1, 0);
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(8'h93, 1'b1, 0);
`endif
    wait_drain("t1_drain");
    check("t1_busy_idle", {31'd0, rx_busy}, 0);

    // hdr on/off, then take_pic
    send_packet(8'h03, 8'h00, 8'h01, -1, 1'b0, 0);
    send_packet(8'h03, 8'h00, 8'h00, -1, 1'b0, 0);
    send_packet(8'h02, 8'h00, 8'h00, -1, 1'b0, 0);
    wait_drain("t2_drain");

    // junk before sync is dropped silently
    send_byte(8'h00, 1'b1, 0);
    send_byte(8'hFF, 1'b1, 0);
    send_packet(8'h02, 8'h00, 8'h00, -1, 1'b0, 0);
    wait_drain("t3_drain");

    // framing error on the third byte, then a good packet
    send_packet(8'h01, 8'h34, 8'h56, 2, 1'b0, 0);
    check("t4_busy_cleared", {31'd0, rx_busy}, 0);
    send_packet(8'h01, 8'h34, 8'h56, -1, 1'b0, 1);
    wait_drain("t4_drain");

    // unknown command and (when enabled) bad checksum
    send_packet(8'h07, 8'h00, 8'h00, -1, 1'b0, 0);
`ifdef UART_CMD_CHECKSUM_EN
    send_packet(8'h01, 8'h12, 8'h80, -1, 1'b1, 0);
`endif
    wait_drain("t5_drain");

    // inter-byte timeout
    push_ev(K_ERR);
    send_byte(8'hA5, 1'b1, 0);
    send_byte(8'h01, 1'b1, 0);
    t0 = cyc;
    check("t6_busy_waiting", {31'd0, rx_busy}, 1);
    t = 0;
    while (!cmd_err && t < TO_LIMIT + 100) begin
      @(negedge clk);
      t++;
    end
    check("t6_timeout_window", {31'd0, (cyc - t0 >= TO_LIMIT - CPB) && (cyc - t0 <= TO_LIMIT + 4)}, 1);
    @(negedge clk);
    check("t6_busy_cleared", {31'd0, rx_busy}, 0);
    wait_drain("t6_drain");

    // short glitch is not a byte
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("glitch_busy", {31'd0, rx_busy}, 0);

    // reset in the middle of a byte and a packet
    send_packet(8'h03, 8'h00, 8'h01, -1, 1'b0, 0);
    wait_drain("rst_pre_drain");
    send_byte(8'hA5, 1'b1, 0);
    send_byte(8'h01, 1'b1, 0);
    rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    check("midbyte_reset_outputs", {conf_addr, conf_data, 3'd0, sccb_start, take_pic, hdr_en, cmd_err, rx_busy}, 32'd0);
    rst = 1'b0;
    m_addr = 8'h00; m_data = 8'h00; m_hdr = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    send_packet(8'h01, 8'h5C, 8'hC3, -1, 1'b0, 0);
    wait_drain("post_reset_drain");

    // randomized packets
    for (int p = 0; p < 24; p++) begin
      case ($urandom_range(3))
        0: c = 8'h01;
        1: c = 8'h02;
        2: c = 8'h03;
        default: begin
          c = 8'($urandom_range(255));
          if (c inside {8'h01, 8'h02, 8'h03}) c = 8'h44;
        end
      endcase
      if ($urandom_range(3) == 0) begin
        j = 8'($urandom_range(255));
        if (j == 8'hA5) j = 8'h5A;
        send_byte(j, 1'b1, $urandom_range(1));
      end
      send_packet(c, 8'($urandom_range(255)), 8'($urandom_range(255)),
                  ($urandom_range(7) == 0) ? int'($urandom_range(3)) : -1,
`ifdef UART_CMD_CHECKSUM_EN
                  ($urandom_range(5) == 0),
`else
                  1'b0,
`endif
                  $urandom_range(2));
    end
    wait_drain("random_drain");
    repeat (4 * CPB) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
